// File: rtl/encode_mul_arbiter.sv
// Round-robin arbiter that shares one external pipelined multiplier among NUM_REQ
// requesters and returns each product on a single tagged valid/ready response port.
module encode_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*40-1:0]   req_a,
    input  logic [NUM_REQ*21-1:0]   req_b,
    output logic                    mul_ce,
    output logic [39:0]             mul_din0,
    output logic [20:0]             mul_din1,
    input  logic [59:0]             mul_dout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [59:0]             rsp_data,
    output logic [CNT_W-1:0]        op_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [39:0]        a_arr [NUM_REQ];
    logic [20:0]        b_arr [NUM_REQ];

    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W:0]     srch_idx;
    logic               grant_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[40*gi +: 40];
            assign b_arr[gi] = req_b[21*gi +: 21];
        end
    endgenerate

    // The multiplier advances whenever its output slot is empty or being drained.
    assign mul_ce = ~s1_valid_q | rsp_ready;
    // No operand may be accepted while reset is held, even if requesters keep valid high.
    assign grant_en = mul_ce & reset_n;

    always_comb begin : rr_search
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        srch_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            srch_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (srch_idx >= (PTR_W+1)'(NUM_REQ)) begin
                srch_idx = srch_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!gnt_any && req_valid[srch_idx[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = srch_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin : next_state
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;
        req_ready  = '0;
        mul_din0   = '0;
        mul_din1   = '0;
        if (grant_en) begin
            // An idle slot still clocks the multiplier; the zero product is simply never marked valid.
            s1_valid_d = gnt_any;
            if (gnt_any) begin
                s1_id_d            = ID_W'(gnt_idx);
                rr_ptr_d           = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                req_ready[gnt_idx] = 1'b1;
                mul_din0           = a_arr[gnt_idx];
                mul_din1           = b_arr[gnt_idx];
            end
        end
        if (s1_valid_q && rsp_ready) begin
            op_count_d = op_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            rr_ptr_q   <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = s1_valid_q;
    assign rsp_id    = s1_id_q;
    assign rsp_data  = mul_dout;
    assign op_count  = op_count_q;

endmodule
